// File: rtl/ai_paddle_ctrl.sv
// Left-side computer opponent: snapshots the balls and paddles on each frame strobe,
// scans the five balls for the nearest incoming one, then issues a single paddle move code.
module ai_paddle_ctrl #(
  parameter int HEIGHT    = 480,
  parameter int PAD11_X   = 61,
  parameter int PAD_WIDTH = 4,
  parameter int DEADBAND  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stclk,
  input  logic               enable,
  input  logic [54:0]        ball_posx_bus,
  input  logic [54:0]        ball_posy_bus,
  input  logic [54:0]        ball_velx_bus,
  input  logic signed [10:0] paddle10_posy,
  input  logic signed [10:0] paddle11_posy,
  output logic [2:0]         AI_M,
  output logic [2:0]         target,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DECIDE = 2'd2} state_e;

  localparam logic [2:0]         NONE     = 3'd7;
  localparam logic signed [11:0] CENTRE   = 12'(HEIGHT / 2);
  localparam logic signed [11:0] PAD_EDGE = 12'(PAD11_X + PAD_WIDTH);
  localparam logic signed [11:0] DB_POS   = 12'(DEADBAND);
  localparam logic signed [11:0] DB_NEG   = -12'(DEADBAND);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        best_q, best_d;
  logic signed [10:0] best_x_q, best_x_d;
  logic signed [10:0] best_y_q, best_y_d;
  logic signed [10:0] snap_x_q [5];
  logic signed [10:0] snap_x_d [5];
  logic signed [10:0] snap_y_q [5];
  logic signed [10:0] snap_y_d [5];
  logic [4:0]        snap_v_q, snap_v_d;
  logic signed [10:0] pad10_q, pad10_d;
  logic signed [10:0] pad11_q, pad11_d;
  logic [2:0]        ai_m_q, ai_m_d;
  logic [2:0]        target_q, target_d;

  // Only the sign of each x velocity matters; the magnitude bits are intentionally dropped.
  logic unused_velx;
  assign unused_velx = ^ball_velx_bus;

  // Move decision from the scan result (or recentre when nothing is incoming).
  logic signed [11:0] off10, off11, abs10, abs11, diff;
  logic               use_p11;
  logic [2:0]         move_code;

  always_comb begin
    off10 = $signed({pad10_q[10], pad10_q}) - CENTRE;
    off11 = $signed({pad11_q[10], pad11_q}) - CENTRE;
    abs10 = off10[11] ? -off10 : off10;
    abs11 = off11[11] ? -off11 : off11;
    if (best_q != NONE) begin
      use_p11 = $signed({best_x_q[10], best_x_q}) > PAD_EDGE;
      diff    = $signed({best_y_q[10], best_y_q}) -
                (use_p11 ? $signed({pad11_q[10], pad11_q}) : $signed({pad10_q[10], pad10_q}));
    end else begin
      use_p11 = abs11 > abs10;
      diff    = use_p11 ? -off11 : -off10;
    end
    move_code = 3'd0;
    if (diff > DB_POS)      move_code = use_p11 ? 3'd3 : 3'd1;
    else if (diff < DB_NEG) move_code = use_p11 ? 3'd4 : 3'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      best_q   <= NONE;
      best_x_q <= '0;
      best_y_q <= '0;
      for (int i = 0; i < 5; i++) begin
        snap_x_q[i] <= '0;
        snap_y_q[i] <= '0;
      end
      snap_v_q <= '0;
      pad10_q  <= '0;
      pad11_q  <= '0;
      ai_m_q   <= '0;
      target_q <= NONE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      best_x_q <= best_x_d;
      best_y_q <= best_y_d;
      snap_x_q <= snap_x_d;
      snap_y_q <= snap_y_d;
      snap_v_q <= snap_v_d;
      pad10_q  <= pad10_d;
      pad11_q  <= pad11_d;
      ai_m_q   <= ai_m_d;
      target_q <= target_d;
    end
  end

  // Priority: disable beats strobe, strobe beats the scan in progress.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    best_d   = best_q;
    best_x_d = best_x_q;
    best_y_d = best_y_q;
    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    snap_v_d = snap_v_q;
    pad10_d  = pad10_q;
    pad11_d  = pad11_q;
    ai_m_d   = ai_m_q;
    target_d = target_q;
    if (!enable) begin
      state_d  = IDLE;
      ai_m_d   = 3'd0;
      target_d = NONE;
    end else if (stclk) begin
      for (int i = 0; i < 5; i++) begin
        snap_x_d[i] = ball_posx_bus[11*i +: 11];
        snap_y_d[i] = ball_posy_bus[11*i +: 11];
        snap_v_d[i] = ball_velx_bus[11*i + 10];
      end
      pad10_d = paddle10_posy;
      pad11_d = paddle11_posy;
      idx_d   = 3'd0;
      best_d  = NONE;
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN: begin
          // Strict less-than keeps the lower index on equal x.
          if (snap_v_q[idx_q] && (best_q == NONE || snap_x_q[idx_q] < best_x_q)) begin
            best_d   = idx_q;
            best_x_d = snap_x_q[idx_q];
            best_y_d = snap_y_q[idx_q];
          end
          if (idx_q == 3'd4) state_d = DECIDE;
          else               idx_d   = idx_q + 3'd1;
        end
        DECIDE: begin
          target_d = best_q;
          ai_m_d   = move_code;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // busy also covers the capture cycle, while the strobe is being sampled.
  always_comb begin
    AI_M      = ai_m_q;
    target    = target_q;
    busy      = (state_q != IDLE) || (stclk && enable);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Bench for ai_paddle_ctrl: directed frames plus random frames with restarts and aborts,
// checked by a queue-based scoreboard that compares whenever busy drops.
module tb_ai_paddle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stclk, enable;
  logic [54:0] ball_posx_bus, ball_posy_bus, ball_velx_bus;
  logic signed [10:0] paddle10_posy, paddle11_posy;
  logic [2:0]  AI_M, target;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  ai_paddle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stclk(stclk), .enable(enable),
    .ball_posx_bus(ball_posx_bus), .ball_posy_bus(ball_posy_bus),
    .ball_velx_bus(ball_velx_bus),
    .paddle10_posy(paddle10_posy), .paddle11_posy(paddle11_posy),
    .AI_M(AI_M), .target(target), .busy(busy), .state_dbg(state_dbg)
  );

  int bx[5], by[5], bv[5];
  int p10, p11;
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: nearest incoming ball wins, else recentre the paddle farther from centre.
  function automatic logic [5:0] model();
    int best, d, o10, o11, a10, a11;
    bit sel11;
    logic [2:0] tgt, code;
    best = -1;
    for (int i = 0; i < 5; i++)
      if (bv[i] < 0 && (best < 0 || bx[i] < bx[best])) best = i;
    if (best >= 0) begin
      sel11 = bx[best] > 65;
      d     = by[best] - (sel11 ? p11 : p10);
      tgt   = 3'(best);
    end else begin
      o10 = p10 - 240;
      o11 = p11 - 240;
      a10 = o10 < 0 ? -o10 : o10;
      a11 = o11 < 0 ? -o11 : o11;
      sel11 = a11 > a10;
      d     = sel11 ? -o11 : -o10;
      tgt   = 3'd7;
    end
    if (d > 6)       code = sel11 ? 3'd3 : 3'd1;
    else if (d < -6) code = sel11 ? 3'd4 : 3'd2;
    else             code = 3'd0;
    return {tgt, code};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < 5; i++) begin
      ball_posx_bus[11*i +: 11] = 11'(bx[i]);
      ball_posy_bus[11*i +: 11] = 11'(by[i]);
      ball_velx_bus[11*i +: 11] = 11'(bv[i]);
    end
    paddle10_posy = 11'(p10);
    paddle11_posy = 11'(p11);
  endtask

  task automatic scramble_bus();
    ball_posx_bus = 55'({$urandom(), $urandom()});
    ball_posy_bus = 55'({$urandom(), $urandom()});
    ball_velx_bus = 55'({$urandom(), $urandom()});
    paddle10_posy = 11'($urandom());
    paddle11_posy = 11'($urandom());
  endtask

  task automatic replace_tail(input logic [5:0] v);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(v);
  endtask

  task automatic issue(input bit restart);
    apply();
    if (restart) replace_tail(model());
    else         exp_q.push_back(model());
    stclk = 1'b1;
    tick();
    stclk = 1'b0;
  endtask

  task automatic set_all(input int x, input int y, input int v);
    for (int i = 0; i < 5; i++) begin
      bx[i] = x; by[i] = y; bv[i] = v;
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 5; i++) begin
      bx[i] = int'($urandom_range(0, 639));
      by[i] = int'($urandom_range(0, 580)) - 50;
      bv[i] = ($urandom_range(0, 9) < 3) ? -int'($urandom_range(1, 5)) : int'($urandom_range(0, 5));
    end
    p10 = int'($urandom_range(0, 480));
    p11 = int'($urandom_range(0, 480));
  endtask

  task automatic load_t2();
    set_all(500, 0, 2);
    bx[2] = 300; by[2] = 100; bv[2] = -3;
    p10 = 100; p11 = 240;
  endtask

  task automatic load_t3();
    set_all(500, 0, 1);
    bx[0] = 200; bv[0] = -1;
    bx[3] = 40; by[3] = 400; bv[3] = -1;
    p10 = 240; p11 = 100;
  endtask

  // Scoreboard monitor: a busy falling edge means a result (or an abort) is on the outputs.
  logic       busy_prev = 1'b0;
  int         busy_run = 0;
  int         last_busy_len = 0;
  logic [5:0] mon_e;

  always @(negedge clk) begin
    if (busy) busy_run++;
    if (busy_prev && !busy) begin
      last_busy_len = busy_run;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected actual target=%0d ai_m=%0d required no result", target, AI_M);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_target", int'(target), int'(mon_e[5:3]));
        check("result_ai_m", int'(AI_M), int'(mon_e[2:0]));
      end
    end
    if (!busy) busy_run = 0;
    busy_prev = busy;
  end

  initial begin
    rst_n = 1'b0; stclk = 1'b0; enable = 1'b1;
    set_all(0, 0, 0); p10 = 0; p11 = 0;
    apply();
    tick(); tick();
    check("reset_ai_m", int'(AI_M), 0);
    check("reset_target", int'(target), 7);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Single incoming ball, latency and busy width.
    load_t2();
    issue(0);
    repeat (5) tick();
    check("t2_before_decide_ai_m", int'(AI_M), 0);
    tick();
    check("t2_target", int'(target), 2);
    check("t2_ai_m", int'(AI_M), 4);
    tick(); tick();
    check("t2_busy_len", last_busy_len, 7);

    // Nearest of two incoming balls, paddle10 side.
    load_t3();
    issue(0);
    repeat (8) tick();
    check("t3_target", int'(target), 3);
    check("t3_ai_m", int'(AI_M), 1);

    // Equal x: lower index wins.
    set_all(500, 300, 1);
    bx[1] = 150; bv[1] = -2; bx[4] = 150; bv[4] = -2; by[4] = 0;
    p10 = 240; p11 = 240;
    issue(0);
    repeat (8) tick();
    check("t4_target", int'(target), 1);

    // No threats: recentre.
    set_all(500, 0, 1); p10 = 240; p11 = 300;
    issue(0);
    repeat (8) tick();
    check("t5_recentre_ai_m", int'(AI_M), 4);
    check("t5_recentre_target", int'(target), 7);
    p10 = 246; p11 = 234;
    issue(0);
    repeat (8) tick();
    check("t5_deadband_ai_m", int'(AI_M), 0);

    // Deadband edges on both paddles.
    for (int k = 0; k < 6; k++) begin
      set_all(500, 0, 1);
      bv[0] = -1;
      bx[0] = (k < 3) ? 300 : 50;
      p10 = 200; p11 = 200;
      by[0] = (k % 3 == 0) ? 206 : (k % 3 == 1) ? 207 : 193;
      issue(0);
      repeat (8) tick();
    end

    // Restart on scan edge 3 with a different snapshot.
    load_t2();
    issue(0);
    repeat (2) tick();
    load_t3();
    issue(1);
    repeat (8) tick();
    check("t6_restart_target", int'(target), 3);
    check("t6_restart_ai_m", int'(AI_M), 1);

    // Asynchronous reset mid-scan.
    load_t2();
    issue(0);
    repeat (2) tick();
    replace_tail({3'd7, 3'd0});
    rst_n = 1'b0;
    #1;
    check("async_rst_ai_m", int'(AI_M), 0);
    check("async_rst_target", int'(target), 7);
    check("async_rst_busy", int'(busy), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Disable forces hold; strobe ignored while disabled.
    load_t2();
    issue(0);
    repeat (8) tick();
    check("en_pre_ai_m", int'(AI_M), 4);
    enable = 1'b0;
    tick();
    check("en_off_ai_m", int'(AI_M), 0);
    check("en_off_target", int'(target), 7);
    load_t3();
    apply();
    stclk = 1'b1;
    #1;
    check("en_off_stclk_busy", int'(busy), 0);
    tick();
    stclk = 1'b0;
    repeat (7) tick();
    check("en_off_late_ai_m", int'(AI_M), 0);
    check("en_off_late_busy", int'(busy), 0);
    enable = 1'b1;
    tick();

    // Random frames with restarts and aborts.
    for (int f = 0; f < 200; f++) begin
      int mode, k;
      mode = int'($urandom_range(0, 3));
      rand_inputs();
      issue(0);
      if (mode == 2) begin
        k = int'($urandom_range(0, 5));
        repeat (k) begin scramble_bus(); tick(); end
        rand_inputs();
        issue(1);
      end
      if (mode == 3) begin
        k = int'($urandom_range(0, 5));
        repeat (k) begin scramble_bus(); tick(); end
        replace_tail({3'd7, 3'd0});
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (2) tick();
      end else begin
        repeat (8) begin scramble_bus(); tick(); end
      end
    end

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
